// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell is reused for every bit,
// LSB first, with the carry held in a register between cycles.

// Single-bit full adder cell shared by the serial and ripple adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .cout (fa_cout),
    .sum  (fa_sum)
  );

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update: load on accepted start, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // Counter parks at the last bit; the result is published only here.
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from registers only.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[7];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, bounded; reports negedges taken, busy cycles seen and overlap.
  task automatic wait_done(output int cyc, output int busy_cyc, output int overlap, output bit seen);
    cyc = 0; busy_cyc = 0; overlap = 0; seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cyc = i;
      if (busy && done) overlap++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  initial begin
    int  cyc, bcyc, ovl, dcount;
    bit  seen;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("reset_sum",  {24'd0, sum}, 32'h00);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", {31'd0, busy}, 32'd0);
    check("idle_no_start_done", {31'd0, done}, 32'd0);

    // Table-driven additions.
    for (int k = 0; k < 7; k++) begin
      start_op(vecs[k].a, vecs[k].b, vecs[k].cin);
      check($sformatf("v%0d_busy_after_start", k), {31'd0, busy}, 32'd1);
      wait_done(cyc, bcyc, ovl, seen);
      check($sformatf("v%0d_done_seen", k), {31'd0, seen}, 32'd1);
      check($sformatf("v%0d_latency", k), cyc, W);
      check($sformatf("v%0d_busy_cycles", k), bcyc, W - 1);
      check($sformatf("v%0d_overlap", k), ovl, 0);
      check($sformatf("v%0d_sum", k), {24'd0, sum}, {24'd0, vecs[k].exp_sum});
      check($sformatf("v%0d_cout", k), {31'd0, cout}, {31'd0, vecs[k].exp_cout});
      @(negedge clk);
      check($sformatf("v%0d_done_single", k), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_idle_after", k), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_sum_hold", k), {24'd0, sum}, {24'd0, vecs[k].exp_sum});
    end

    // Start pulsed during RUN must be ignored.
    start_op(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'hAA; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcyc, ovl, seen);
    check("ign_done_seen", {31'd0, seen}, 32'd1);
    check("ign_latency", cyc, W - 3);
    check("ign_sum", {24'd0, sum}, 32'h46);
    check("ign_cout", {31'd0, cout}, 32'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("ign_no_second_op", dcount, 0);

    // Back-to-back: restart in the DONE cycle.
    start_op(8'h80, 8'h80, 1'b0);
    wait_done(cyc, bcyc, ovl, seen);
    check("b2b_first_seen", {31'd0, seen}, 32'd1);
    check("b2b_first_sum", {24'd0, sum}, 32'h00);
    check("b2b_first_cout", {31'd0, cout}, 32'd1);
    a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_no_gap", {31'd0, busy}, 32'd1);
    check("b2b_sum_hold_run", {24'd0, sum}, 32'h00);
    check("b2b_cout_hold_run", {31'd0, cout}, 32'd1);
    wait_done(cyc, bcyc, ovl, seen);
    check("b2b_second_seen", {31'd0, seen}, 32'd1);
    check("b2b_spacing", cyc + 1, W + 1);
    check("b2b_second_sum", {24'd0, sum}, 32'h08);
    check("b2b_second_cout", {31'd0, cout}, 32'd0);

    // Reset in the middle of RUN, asserted between clock edges.
    start_op(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum", {24'd0, sum}, 32'h00);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_sum_after", {24'd0, sum}, 32'h00);
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(cyc, bcyc, ovl, seen);
    check("rerun_seen", {31'd0, seen}, 32'd1);
    check("rerun_latency", cyc, W);
    check("rerun_sum", {24'd0, sum}, 32'h80);
    check("rerun_cout", {31'd0, cout}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
